// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical memory port between an instruction-side
// read port and a data-side read/write port. The data side wins ties. Each
// transaction latches its address and write data at grant, so requester
// inputs may change while the transaction is in flight. Every output is
// driven from a register.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [DATA_W-1:0] pmem_wdata,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic [DATA_W-1:0] wdata_r, wdata_nxt_s;
  logic              pmem_read_r, pmem_read_nxt_s;
  logic              pmem_write_r, pmem_write_nxt_s;
  logic              i_resp_r, i_resp_nxt_s;
  logic              d_resp_r, d_resp_nxt_s;
  logic [DATA_W-1:0] i_rdata_r, i_rdata_nxt_s;
  logic [DATA_W-1:0] d_rdata_r, d_rdata_nxt_s;
  logic              i_req_s, d_req_s;

  // A port whose response is showing this cycle has not yet had a chance
  // to drop its level request, so it is masked out of arbitration.
  always_comb begin
    i_req_s = i_read & ~i_resp_r;
    d_req_s = (d_read | d_write) & ~d_resp_r;
  end

  // Next-state and next-output logic: arbitrate in IDLE, wait for pmem_resp when serving.
  always_comb begin
    state_nxt_s      = state_r;
    addr_nxt_s       = addr_r;
    wdata_nxt_s      = wdata_r;
    pmem_read_nxt_s  = pmem_read_r;
    pmem_write_nxt_s = pmem_write_r;
    i_resp_nxt_s     = 1'b0;
    d_resp_nxt_s     = 1'b0;
    i_rdata_nxt_s    = i_rdata_r;
    d_rdata_nxt_s    = d_rdata_r;
    case (state_r)
      IDLE: begin
        pmem_read_nxt_s  = 1'b0;
        pmem_write_nxt_s = 1'b0;
        if (d_req_s) begin
          state_nxt_s = SERVE_D;
          addr_nxt_s  = d_addr;
          // A simultaneous read+write request is treated as a write.
          if (d_write) begin
            wdata_nxt_s      = d_wdata;
            pmem_write_nxt_s = 1'b1;
          end else begin
            pmem_read_nxt_s = 1'b1;
          end
        end else if (i_req_s) begin
          state_nxt_s     = SERVE_I;
          addr_nxt_s      = i_addr;
          pmem_read_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          state_nxt_s      = IDLE;
          pmem_read_nxt_s  = 1'b0;
          pmem_write_nxt_s = 1'b0;
          i_resp_nxt_s     = 1'b1;
          i_rdata_nxt_s    = pmem_rdata;
        end else begin
          state_nxt_s = SERVE_I;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          state_nxt_s      = IDLE;
          pmem_read_nxt_s  = 1'b0;
          pmem_write_nxt_s = 1'b0;
          d_resp_nxt_s     = 1'b1;
          // Writes leave the last read data in place.
          if (pmem_read_r) begin
            d_rdata_nxt_s = pmem_rdata;
          end else begin
            d_rdata_nxt_s = d_rdata_r;
          end
        end else begin
          state_nxt_s = SERVE_D;
        end
      end
      default: begin
        state_nxt_s      = IDLE;
        pmem_read_nxt_s  = 1'b0;
        pmem_write_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Transaction and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      pmem_read_r  <= 1'b0;
      pmem_write_r <= 1'b0;
      i_resp_r     <= 1'b0;
      d_resp_r     <= 1'b0;
      i_rdata_r    <= {DATA_W{1'b0}};
      d_rdata_r    <= {DATA_W{1'b0}};
    end else begin
      addr_r       <= addr_nxt_s;
      wdata_r      <= wdata_nxt_s;
      pmem_read_r  <= pmem_read_nxt_s;
      pmem_write_r <= pmem_write_nxt_s;
      i_resp_r     <= i_resp_nxt_s;
      d_resp_r     <= d_resp_nxt_s;
      i_rdata_r    <= i_rdata_nxt_s;
      d_rdata_r    <= d_rdata_nxt_s;
    end
  end

  assign pmem_addr  = addr_r;
  assign pmem_wdata = wdata_r;
  assign pmem_read  = pmem_read_r;
  assign pmem_write = pmem_write_r;
  assign i_resp     = i_resp_r;
  assign d_resp     = d_resp_r;
  assign i_rdata    = i_rdata_r;
  assign d_rdata    = d_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes the expected
// memory transactions and port responses; a negedge monitor pops and checks.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] i_addr = 16'h0000;
  logic        i_read = 1'b0;
  logic [15:0] i_rdata;
  logic        i_resp;
  logic [15:0] d_addr = 16'h0000;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [15:0] d_wdata = 16'h0000;
  logic [15:0] d_rdata;
  logic        d_resp;
  logic [15:0] pmem_addr;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_wdata;
  logic [15:0] pmem_rdata = 16'h0000;
  logic        pmem_resp = 1'b0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_addr(pmem_addr), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          len;
  } pm_t;

  typedef struct {
    logic        is_d;
    logic [15:0] rdata;
  } rsp_t;

  pm_t  pq[$];
  rsp_t rq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor state
  logic in_strobe = 1'b0;
  int   strobe_cnt = 0;
  pm_t  cur;
  pm_t  pm_e;
  rsp_t rs_e;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_strobe  = 1'b0;
        strobe_cnt = 0;
      end else begin
        if (pmem_read || pmem_write) begin
          check("strobe_exclusive", {31'd0, pmem_read & pmem_write}, 32'd0);
        end
        if ((pmem_read || pmem_write) && !in_strobe) begin
          check("pq_nonempty", {31'd0, pq.size() != 0}, 32'd1);
          if (pq.size() != 0) begin
            pm_e = pq.pop_front();
            cur  = pm_e;
            check("pmem_is_write", {31'd0, pmem_write}, {31'd0, pm_e.wr});
            check("pmem_addr", {16'd0, pmem_addr}, {16'd0, pm_e.addr});
            if (pm_e.wr) begin
              check("pmem_wdata", {16'd0, pmem_wdata}, {16'd0, pm_e.wdata});
            end
          end
          in_strobe  = 1'b1;
          strobe_cnt = 1;
        end else if ((pmem_read || pmem_write) && in_strobe) begin
          strobe_cnt++;
          check("pmem_addr_stable", {16'd0, pmem_addr}, {16'd0, cur.addr});
        end else if (in_strobe) begin
          in_strobe = 1'b0;
          check("strobe_len", strobe_cnt, cur.len);
        end
        if (i_resp || d_resp) begin
          check("resp_exclusive", {31'd0, i_resp & d_resp}, 32'd0);
          check("rq_nonempty", {31'd0, rq.size() != 0}, 32'd1);
          if (rq.size() != 0) begin
            rs_e = rq.pop_front();
            check("resp_port_is_d", {31'd0, d_resp}, {31'd0, rs_e.is_d});
            if (rs_e.is_d) begin
              check("d_rdata", {16'd0, d_rdata}, {16'd0, rs_e.rdata});
            end else begin
              check("i_rdata", {16'd0, i_rdata}, {16'd0, rs_e.rdata});
            end
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory model: wait for a strobe, answer in its lat-th cycle.
  task automatic serve(input int lat, input logic [15:0] rd);
    int n;
    n = 0;
    while (!(pmem_read || pmem_write) && n < 20) begin
      idle(1);
      n++;
    end
    check("strobe_seen", {31'd0, pmem_read | pmem_write}, 32'd1);
    if (pmem_read || pmem_write) begin
      idle(lat - 1);
      pmem_rdata = rd;
      pmem_resp  = 1'b1;
      idle(1);
      pmem_resp  = 1'b0;
    end
  endtask

  task automatic wait_resp(input logic is_d);
    int n;
    n = 0;
    while (!(is_d ? d_resp : i_resp) && n < 20) begin
      idle(1);
      n++;
    end
    check(is_d ? "d_resp_seen" : "i_resp_seen", {31'd0, (is_d ? d_resp : i_resp)}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, asynchronous
    #1 reset_n = 1'b0;
    #1;
    check("rst_pmem_read", {31'd0, pmem_read}, 32'd0);
    check("rst_pmem_write", {31'd0, pmem_write}, 32'd0);
    check("rst_i_resp", {31'd0, i_resp}, 32'd0);
    check("rst_d_resp", {31'd0, d_resp}, 32'd0);
    check("rst_pmem_addr", {16'd0, pmem_addr}, 32'd0);
    check("rst_pmem_wdata", {16'd0, pmem_wdata}, 32'd0);
    check("rst_i_rdata", {16'd0, i_rdata}, 32'd0);
    check("rst_d_rdata", {16'd0, d_rdata}, 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(1);

    // Instruction read, 3-cycle memory latency
    pq.push_back('{wr: 1'b0, addr: 16'h0040, wdata: 16'h0000, len: 3});
    rq.push_back('{is_d: 1'b0, rdata: 16'h1234});
    i_addr = 16'h0040;
    i_read = 1'b1;
    serve(3, 16'h1234);
    wait_resp(1'b0);
    i_read = 1'b0;
    idle(2);

    // Simultaneous I read and D write: data side first, one idle gap
    pq.push_back('{wr: 1'b1, addr: 16'h0100, wdata: 16'hBEEF, len: 2});
    pq.push_back('{wr: 1'b0, addr: 16'h0050, wdata: 16'h0000, len: 1});
    rq.push_back('{is_d: 1'b1, rdata: 16'h0000});
    rq.push_back('{is_d: 1'b0, rdata: 16'h5555});
    i_addr  = 16'h0050;
    i_read  = 1'b1;
    d_addr  = 16'h0100;
    d_wdata = 16'hBEEF;
    d_write = 1'b1;
    serve(2, 16'hAAAA);
    wait_resp(1'b1);
    check("gap_strobes_low", {30'd0, pmem_read, pmem_write}, 32'd0);
    d_write = 1'b0;
    idle(1);
    check("i_after_gap", {31'd0, pmem_read}, 32'd1);
    serve(1, 16'h5555);
    wait_resp(1'b0);
    i_read = 1'b0;
    idle(2);

    // D read held through its response: I granted, not D again
    pq.push_back('{wr: 1'b0, addr: 16'h0010, wdata: 16'h0000, len: 1});
    pq.push_back('{wr: 1'b0, addr: 16'h0020, wdata: 16'h0000, len: 2});
    rq.push_back('{is_d: 1'b1, rdata: 16'h0D0D});
    rq.push_back('{is_d: 1'b0, rdata: 16'h1111});
    d_addr = 16'h0010;
    d_read = 1'b1;
    i_addr = 16'h0020;
    i_read = 1'b1;
    serve(1, 16'h0D0D);
    wait_resp(1'b1);
    idle(1);
    check("held_d_masked_addr", {16'd0, pmem_addr}, 32'h0020);
    d_read = 1'b0;
    serve(2, 16'h1111);
    wait_resp(1'b0);
    i_read = 1'b0;
    idle(2);

    // D address changes mid-transaction
    pq.push_back('{wr: 1'b0, addr: 16'h0200, wdata: 16'h0000, len: 3});
    rq.push_back('{is_d: 1'b1, rdata: 16'h2222});
    d_addr = 16'h0200;
    d_read = 1'b1;
    idle(1);
    d_addr = 16'h0300;
    idle(1);
    check("addr_held", {16'd0, pmem_addr}, 32'h0200);
    serve(2, 16'h2222);
    wait_resp(1'b1);
    d_read = 1'b0;
    idle(2);

    // Read+write together: write only, d_rdata unchanged
    pq.push_back('{wr: 1'b1, addr: 16'h0400, wdata: 16'h1357, len: 1});
    rq.push_back('{is_d: 1'b1, rdata: 16'h2222});
    d_addr  = 16'h0400;
    d_wdata = 16'h1357;
    d_read  = 1'b1;
    d_write = 1'b1;
    serve(1, 16'h9999);
    wait_resp(1'b1);
    d_read  = 1'b0;
    d_write = 1'b0;
    idle(2);

    // Reset during SERVE_I, stale pmem_resp, then a fresh request
    pq.push_back('{wr: 1'b0, addr: 16'h0600, wdata: 16'h0000, len: 0});
    i_addr = 16'h0600;
    i_read = 1'b1;
    idle(2);
    #2 reset_n = 1'b0;
    #1;
    check("abort_pmem_read", {31'd0, pmem_read}, 32'd0);
    check("abort_pmem_addr", {16'd0, pmem_addr}, 32'd0);
    check("abort_i_resp", {31'd0, i_resp}, 32'd0);
    i_read = 1'b0;
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    pmem_rdata = 16'hDEAD;
    pmem_resp  = 1'b1;
    idle(1);
    pmem_resp = 1'b0;
    check("late_resp_i_resp", {31'd0, i_resp}, 32'd0);
    check("late_resp_pmem_read", {31'd0, pmem_read}, 32'd0);
    check("late_resp_i_rdata", {16'd0, i_rdata}, 32'd0);
    idle(1);
    pq.push_back('{wr: 1'b0, addr: 16'h0700, wdata: 16'h0000, len: 2});
    rq.push_back('{is_d: 1'b0, rdata: 16'h7777});
    i_addr = 16'h0700;
    i_read = 1'b1;
    idle(1);
    check("grant_after_reset", {31'd0, pmem_read}, 32'd1);
    serve(2, 16'h7777);
    wait_resp(1'b0);
    i_read = 1'b0;
    idle(3);

    check("pq_drained", pq.size(), 32'd0);
    check("rq_drained", rq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
